// File: rtl/fl_checkpoint_ctrl.sv
// Branch checkpoint controller for the dispatch-stage physical-register freelist.
// Snapshots the freelist head per dispatched branch and drives head recovery on mispredicts.
module fl_checkpoint_ctrl #(
  parameter int unsigned NUM_CKPT    = 8,
  parameter int unsigned CKPT_W      = 3,
  parameter int unsigned FL_IDX_W    = 5,
  parameter int unsigned RECOVER_LAT = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [2:0]            disp_valid,
  input  logic [2:0]            disp_is_branch,
  input  logic [2:0]            disp_dest_alloc,
  input  logic [FL_IDX_W-1:0]   fl_head,
  output logic                  disp_stall,
  output logic [3*CKPT_W-1:0]   disp_ckpt_id,
  input  logic                  res_valid,
  input  logic [CKPT_W-1:0]     res_ckpt_id,
  input  logic                  res_mispredict,
  output logic                  bp_recover_en,
  output logic [FL_IDX_W-1:0]   bp_recover_head,
  output logic                  recover_busy,
  output logic [CKPT_W:0]       ckpt_free_count
);

  localparam int unsigned LatW = (RECOVER_LAT > 1) ? $clog2(RECOVER_LAT) : 1;

  typedef enum logic [1:0] {StNormal, StRecover, StBlock} state_e;

  state_e              state_q;
  logic [LatW-1:0]     lat_cnt_q;
  logic [NUM_CKPT-1:0] valid_q, valid_d;
  logic [FL_IDX_W-1:0] head_q [NUM_CKPT];
  logic [CKPT_W-1:0]   old_ptr_q, old_ptr_d;
  logic [CKPT_W-1:0]   alloc_ptr_q, alloc_ptr_d;
  logic [CKPT_W:0]     count_q, count_d;

  logic [2:0]          br, al;
  logic [1:0]          nb;
  logic [CKPT_W-1:0]   slot_id   [3];
  logic [FL_IDX_W-1:0] slot_head [3];
  logic [CKPT_W:0]     free_now;
  logic                tgt_valid, free_ok, mp_hit, mp_accept, do_disp, gc;
  logic [CKPT_W:0]     span, sq_cnt;
  logic [NUM_CKPT-1:0] sq;

  assign recover_busy    = (state_q != StNormal);
  assign ckpt_free_count = (CKPT_W+1)'(NUM_CKPT) - count_q;

  always_comb begin
    br = disp_valid & disp_is_branch;
    al = disp_valid & disp_dest_alloc;
    nb = 2'(br[2]) + 2'(br[1]) + 2'(br[0]);

    // Slot 2 is oldest: IDs and heads accumulate from slot 2 downwards.
    slot_id[2]   = alloc_ptr_q;
    slot_id[1]   = alloc_ptr_q + CKPT_W'(br[2]);
    slot_id[0]   = alloc_ptr_q + CKPT_W'(br[2]) + CKPT_W'(br[1]);
    slot_head[2] = fl_head + FL_IDX_W'(al[2]);
    slot_head[1] = slot_head[2] + FL_IDX_W'(al[1]);
    slot_head[0] = slot_head[1] + FL_IDX_W'(al[0]);

    disp_ckpt_id = '0;
    for (int k = 0; k < 3; k++) begin
      disp_ckpt_id[k*CKPT_W +: CKPT_W] = slot_id[k];
    end

    free_now   = (CKPT_W+1)'(NUM_CKPT) - count_q;
    tgt_valid  = valid_q[res_ckpt_id];
    free_ok    = res_valid & ~res_mispredict & tgt_valid;
    mp_hit     = res_valid & res_mispredict & tgt_valid;
    mp_accept  = mp_hit & (state_q != StRecover);
    disp_stall = ((CKPT_W+1)'(nb) > free_now) | recover_busy | mp_hit;
    do_disp    = ~disp_stall & (nb != 2'd0);
    gc         = (old_ptr_q != alloc_ptr_q) & ~valid_q[old_ptr_q];

    // alloc_ptr == m with m live means the ring is full, so squash every entry.
    span = (CKPT_W+1)'(alloc_ptr_q - res_ckpt_id);
    if (span == '0) span = (CKPT_W+1)'(NUM_CKPT);
    sq     = '0;
    sq_cnt = '0;
    for (int i = 0; i < NUM_CKPT; i++) begin
      sq[i]  = mp_accept & valid_q[i] &
               ((CKPT_W+1)'(CKPT_W'(i) - res_ckpt_id) < span);
      sq_cnt = sq_cnt + (CKPT_W+1)'(sq[i]);
    end

    valid_d = valid_q;
    if (free_ok) valid_d[res_ckpt_id] = 1'b0;
    valid_d = valid_d & ~sq;
    if (do_disp) begin
      for (int k = 0; k < 3; k++) begin
        if (br[k]) valid_d[slot_id[k]] = 1'b1;
      end
    end

    if (mp_accept)    alloc_ptr_d = res_ckpt_id;
    else if (do_disp) alloc_ptr_d = alloc_ptr_q + CKPT_W'(nb);
    else              alloc_ptr_d = alloc_ptr_q;

    old_ptr_d = gc ? old_ptr_q + CKPT_W'(1) : old_ptr_q;
    count_d   = count_q + (CKPT_W+1)'(do_disp ? nb : 2'd0) - (CKPT_W+1)'(free_ok) - sq_cnt;
  end

  always_ff @(posedge clock) begin
    if (do_disp) begin
      for (int k = 0; k < 3; k++) begin
        if (br[k]) head_q[slot_id[k]] <= slot_head[k];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q         <= StNormal;
      lat_cnt_q       <= '0;
      valid_q         <= '0;
      old_ptr_q       <= '0;
      alloc_ptr_q     <= '0;
      count_q         <= '0;
      bp_recover_en   <= 1'b0;
      bp_recover_head <= '0;
    end else begin
      valid_q       <= valid_d;
      old_ptr_q     <= old_ptr_d;
      alloc_ptr_q   <= alloc_ptr_d;
      count_q       <= count_d;
      bp_recover_en <= 1'b0;
      case (state_q)
        StNormal: begin
          if (mp_accept) begin
            state_q         <= StRecover;
            bp_recover_en   <= 1'b1;
            bp_recover_head <= head_q[res_ckpt_id];
          end
        end
        StRecover: begin
          state_q   <= StBlock;
          lat_cnt_q <= LatW'(RECOVER_LAT - 1);
        end
        StBlock: begin
          if (mp_accept) begin
            state_q         <= StRecover;
            bp_recover_en   <= 1'b1;
            bp_recover_head <= head_q[res_ckpt_id];
          end else if (lat_cnt_q == '0) begin
            state_q <= StNormal;
          end else begin
            lat_cnt_q <= lat_cnt_q - LatW'(1);
          end
        end
        default: state_q <= StNormal;
      endcase
    end
  end

endmodule

// File: tb/tb_fl_checkpoint_ctrl.sv
// Directed bench for fl_checkpoint_ctrl: a vector table for dispatch/free/full/wrap
// plus hand-written mispredict, nested-recovery and reset-in-recovery sequences.
module tb_fl_checkpoint_ctrl;

  logic       clock = 1'b0;
  logic       reset;
  logic [2:0] disp_valid, disp_is_branch, disp_dest_alloc;
  logic [4:0] fl_head;
  logic       disp_stall;
  logic [8:0] disp_ckpt_id;
  logic       res_valid;
  logic [2:0] res_ckpt_id;
  logic       res_mispredict;
  logic       bp_recover_en;
  logic [4:0] bp_recover_head;
  logic       recover_busy;
  logic [3:0] ckpt_free_count;

  int n_chk  = 0;
  int n_fail = 0;

  fl_checkpoint_ctrl dut (
    .clock           (clock),
    .reset           (reset),
    .disp_valid      (disp_valid),
    .disp_is_branch  (disp_is_branch),
    .disp_dest_alloc (disp_dest_alloc),
    .fl_head         (fl_head),
    .disp_stall      (disp_stall),
    .disp_ckpt_id    (disp_ckpt_id),
    .res_valid       (res_valid),
    .res_ckpt_id     (res_ckpt_id),
    .res_mispredict  (res_mispredict),
    .bp_recover_en   (bp_recover_en),
    .bp_recover_head (bp_recover_head),
    .recover_busy    (recover_busy),
    .ckpt_free_count (ckpt_free_count)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  typedef struct {
    logic [2:0] v, b, a;
    logic [4:0] fl;
    logic       rv;
    logic [2:0] rid;
    logic       rmp;
    logic       stall;
    logic [2:0] mask;
    logic [2:0] id2, id1, id0;
    logic [3:0] free;
  } vec_t;

  vec_t vecs [20];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Inputs change on the falling edge; combinational outputs are sampled 1ns later.
  task automatic drive(input logic [2:0] v, input logic [2:0] b, input logic [2:0] a,
                       input logic [4:0] fl, input logic rv, input logic [2:0] rid,
                       input logic rmp);
    @(negedge clock);
    disp_valid      = v;
    disp_is_branch  = b;
    disp_dest_alloc = a;
    fl_head         = fl;
    res_valid       = rv;
    res_ckpt_id     = rid;
    res_mispredict  = rmp;
    #1;
  endtask

  task automatic idle();
    drive(3'b000, 3'b000, 3'b000, 5'd0, 1'b0, 3'd0, 1'b0);
  endtask

  task automatic mispredict(input logic [2:0] id);
    drive(3'b000, 3'b000, 3'b000, 5'd0, 1'b1, id, 1'b1);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic reset_dut();
    @(negedge clock);
    reset = 1'b1;
    idle();
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic wait_normal();
    for (int i = 0; i < 10; i++) begin
      if (!recover_busy) break;
      idle();
      step();
    end
    if (recover_busy) chk("wait_normal_timeout", 1, 0);
  endtask

  initial begin
    int busy_cycles;

    //            v       b       a       fl  rv    rid  rmp   stall mask    id2   id1   id0   free
    vecs[0]  = '{3'b111, 3'b100, 3'b111, 5'd30, 1'b0, 3'd0, 1'b0, 1'b0, 3'b100, 3'd0, 3'd0, 3'd0, 4'd7};
    vecs[1]  = '{3'b111, 3'b111, 3'b000, 5'd0,  1'b0, 3'd0, 1'b0, 1'b0, 3'b111, 3'd1, 3'd2, 3'd3, 4'd4};
    vecs[2]  = '{3'b110, 3'b110, 3'b110, 5'd5,  1'b0, 3'd0, 1'b0, 1'b0, 3'b110, 3'd4, 3'd5, 3'd0, 4'd2};
    vecs[3]  = '{3'b111, 3'b111, 3'b000, 5'd0,  1'b0, 3'd0, 1'b0, 1'b1, 3'b000, 3'd0, 3'd0, 3'd0, 4'd2};
    vecs[4]  = '{3'b000, 3'b000, 3'b000, 5'd0,  1'b1, 3'd0, 1'b0, 1'b0, 3'b000, 3'd0, 3'd0, 3'd0, 4'd3};
    vecs[5]  = '{3'b000, 3'b000, 3'b000, 5'd0,  1'b1, 3'd1, 1'b0, 1'b0, 3'b000, 3'd0, 3'd0, 3'd0, 4'd4};
    vecs[6]  = '{3'b000, 3'b000, 3'b000, 5'd0,  1'b1, 3'd2, 1'b0, 1'b0, 3'b000, 3'd0, 3'd0, 3'd0, 4'd5};
    vecs[7]  = '{3'b000, 3'b000, 3'b000, 5'd0,  1'b1, 3'd3, 1'b0, 1'b0, 3'b000, 3'd0, 3'd0, 3'd0, 4'd6};
    vecs[8]  = '{3'b000, 3'b000, 3'b000, 5'd0,  1'b1, 3'd4, 1'b0, 1'b0, 3'b000, 3'd0, 3'd0, 3'd0, 4'd7};
    vecs[9]  = '{3'b000, 3'b000, 3'b000, 5'd0,  1'b1, 3'd5, 1'b0, 1'b0, 3'b000, 3'd0, 3'd0, 3'd0, 4'd8};
    vecs[10] = '{3'b111, 3'b111, 3'b101, 5'd31, 1'b0, 3'd0, 1'b0, 1'b0, 3'b111, 3'd6, 3'd7, 3'd0, 4'd5};
    vecs[11] = '{3'b100, 3'b100, 3'b000, 5'd1,  1'b1, 3'd6, 1'b0, 1'b0, 3'b100, 3'd1, 3'd0, 3'd0, 4'd5};
    vecs[12] = '{3'b111, 3'b111, 3'b000, 5'd0,  1'b0, 3'd0, 1'b0, 1'b0, 3'b111, 3'd2, 3'd3, 3'd4, 4'd2};
    vecs[13] = '{3'b110, 3'b110, 3'b000, 5'd0,  1'b0, 3'd0, 1'b0, 1'b0, 3'b110, 3'd5, 3'd6, 3'd0, 4'd0};
    vecs[14] = '{3'b100, 3'b100, 3'b000, 5'd0,  1'b0, 3'd0, 1'b0, 1'b1, 3'b000, 3'd0, 3'd0, 3'd0, 4'd0};
    vecs[15] = '{3'b111, 3'b000, 3'b111, 5'd0,  1'b0, 3'd0, 1'b0, 1'b0, 3'b000, 3'd0, 3'd0, 3'd0, 4'd0};
    vecs[16] = '{3'b000, 3'b000, 3'b000, 5'd0,  1'b1, 3'd3, 1'b0, 1'b0, 3'b000, 3'd0, 3'd0, 3'd0, 4'd1};
    vecs[17] = '{3'b100, 3'b100, 3'b000, 5'd0,  1'b0, 3'd0, 1'b0, 1'b0, 3'b100, 3'd7, 3'd0, 3'd0, 4'd0};
    vecs[18] = '{3'b000, 3'b000, 3'b000, 5'd0,  1'b1, 3'd3, 1'b0, 1'b0, 3'b000, 3'd0, 3'd0, 3'd0, 4'd0};
    vecs[19] = '{3'b000, 3'b000, 3'b000, 5'd0,  1'b1, 3'd3, 1'b1, 1'b0, 3'b000, 3'd0, 3'd0, 3'd0, 4'd0};

    reset = 1'b1;
    reset_dut();
    idle();
    chk("reset_stall", disp_stall, 0);
    chk("reset_free", ckpt_free_count, 8);
    chk("reset_en", bp_recover_en, 0);
    chk("reset_head", bp_recover_head, 0);
    chk("reset_busy", recover_busy, 0);

    // Dispatch, free, full and wrap table.
    for (int i = 0; i < 20; i++) begin
      logic [2:0] exp_id [3];
      exp_id[2] = vecs[i].id2;
      exp_id[1] = vecs[i].id1;
      exp_id[0] = vecs[i].id0;
      drive(vecs[i].v, vecs[i].b, vecs[i].a, vecs[i].fl, vecs[i].rv, vecs[i].rid, vecs[i].rmp);
      chk($sformatf("vec%0d_stall", i), disp_stall, vecs[i].stall);
      for (int k = 0; k < 3; k++) begin
        if (vecs[i].mask[k]) chk($sformatf("vec%0d_id%0d", i, k), disp_ckpt_id[k*3 +: 3], exp_id[k]);
      end
      step();
      chk($sformatf("vec%0d_free", i), ckpt_free_count, vecs[i].free);
      chk($sformatf("vec%0d_en", i), bp_recover_en, 0);
    end

    // Mispredict with IDs 0..5 live, then a nested mispredict while blocked.
    reset_dut();
    drive(3'b100, 3'b100, 3'b100, 5'd8,  1'b0, 3'd0, 1'b0); step();
    drive(3'b100, 3'b100, 3'b100, 5'd12, 1'b0, 3'd0, 1'b0); step();
    drive(3'b111, 3'b111, 3'b111, 5'd16, 1'b0, 3'd0, 1'b0); step();
    drive(3'b100, 3'b100, 3'b100, 5'd20, 1'b0, 3'd0, 1'b0); step();
    chk("build_free", ckpt_free_count, 2);
    mispredict(3'd2);
    chk("mp2_stall", disp_stall, 1);
    step();
    chk("mp2_en", bp_recover_en, 1);
    chk("mp2_head", bp_recover_head, 17);
    chk("mp2_free", ckpt_free_count, 6);
    chk("mp2_busy", recover_busy, 1);
    mispredict(3'd1);
    step();
    chk("recover_mp_ignored_en", bp_recover_en, 0);
    chk("recover_mp_ignored_free", ckpt_free_count, 6);
    chk("block_busy", recover_busy, 1);
    mispredict(3'd0);
    chk("mp0_stall", disp_stall, 1);
    step();
    chk("mp0_en", bp_recover_en, 1);
    chk("mp0_head", bp_recover_head, 9);
    chk("mp0_free", ckpt_free_count, 8);
    busy_cycles = 0;
    for (int i = 0; i < 10 && recover_busy; i++) begin
      busy_cycles++;
      drive(3'b100, 3'b100, 3'b000, 5'd0, 1'b0, 3'd0, 1'b0);
      chk("busy_stall", disp_stall, 1);
      step();
      if (bp_recover_en) chk("pulse_width", 1, 0);
    end
    chk("busy_len", busy_cycles, 3);
    drive(3'b100, 3'b100, 3'b000, 5'd0, 1'b0, 3'd0, 1'b0);
    chk("post_recover_stall", disp_stall, 0);
    chk("post_recover_id", disp_ckpt_id[8:6], 0);
    disp_valid = 3'b000;
    step();
    chk("post_recover_free", ckpt_free_count, 8);
    mispredict(3'd4);
    chk("squashed_mp_stall", disp_stall, 0);
    step();
    chk("squashed_mp_en", bp_recover_en, 0);
    chk("squashed_mp_busy", recover_busy, 0);
    chk("squashed_mp_free", ckpt_free_count, 8);

    // Stored head includes the branch's own allocation; reset during recovery drops the pulse.
    reset_dut();
    drive(3'b111, 3'b100, 3'b111, 5'd30, 1'b0, 3'd0, 1'b0);
    step();
    mispredict(3'd0);
    step();
    chk("head31_en", bp_recover_en, 1);
    chk("head31_head", bp_recover_head, 31);
    chk("head31_busy", recover_busy, 1);
    idle();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst_recover_en", bp_recover_en, 0);
    chk("rst_recover_free", ckpt_free_count, 8);
    chk("rst_recover_busy", recover_busy, 0);
    drive(3'b100, 3'b100, 3'b000, 5'd0, 1'b0, 3'd0, 1'b0);
    chk("rst_recover_stall", disp_stall, 0);
    idle();
    step();

    // Head arithmetic wraps mod 32 within one group.
    reset_dut();
    drive(3'b111, 3'b111, 3'b101, 5'd31, 1'b0, 3'd0, 1'b0);
    chk("wrap_id2", disp_ckpt_id[8:6], 0);
    chk("wrap_id1", disp_ckpt_id[5:3], 1);
    chk("wrap_id0", disp_ckpt_id[2:0], 2);
    step();
    chk("wrap_free", ckpt_free_count, 5);
    mispredict(3'd2);
    step();
    chk("wrap_head_id2", bp_recover_head, 1);
    chk("wrap_free_id2", ckpt_free_count, 6);
    wait_normal();
    mispredict(3'd1);
    step();
    chk("wrap_head_id1", bp_recover_head, 0);
    chk("wrap_en_id1", bp_recover_en, 1);
    wait_normal();
    mispredict(3'd0);
    step();
    chk("wrap_head_id0", bp_recover_head, 0);
    chk("wrap_free_id0", ckpt_free_count, 8);
    wait_normal();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
